serial_adder: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/serial_adder_digit_adder.sv | 20 ++
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state type and sizing helpers for the serial ALU blocks.
package alu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int step_w(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit adder slice with carry out and carry into its top bit.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] full;

    assign full     = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    assign s        = full[DIGIT-1:0];
    assign cout     = full[DIGIT];
    assign c_msb_in = x[DIGIT-1] ^ y[DIGIT-1] ^ s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial unsigned adder (DIGIT bits per clock) with valid/ready handshakes.
// Defining SERIAL_ADDER_OVERFLOW_EN adds a registered signed-overflow output.
module serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             busy
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int SW    = step_w(WIDTH, DIGIT);

    state_t           state, state_nx;
    logic [SW-1:0]    step;
    logic             carry;
    logic [WIDTH-1:0] a_r, b_r;
    logic [DIGIT-1:0] s;
    logic             cout, c_msb, last;

    assign last = step == SW'(STEPS - 1);

    // Operands shift right one digit per RUN cycle, so the current digit is always the low one.
    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x       (a_r[DIGIT-1:0]),
        .y       (b_r[DIGIT-1:0]),
        .cin     (carry),
        .s       (s),
        .cout    (cout),
        .c_msb_in(c_msb)
    );

`ifndef SERIAL_ADDER_OVERFLOW_EN
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = RUN;
            end
            RUN:  if (last) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, per-digit accumulation and final carry/overflow registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step     <= '0;
            carry    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            sum      <= '0;
            carryout <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= carryin;
            step  <= '0;
        end else if (state == RUN) begin
            a_r   <= a_r >> DIGIT;
            b_r   <= b_r >> DIGIT;
            sum   <= (sum >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
            carry <= cout;
            step  <= step + 1'b1;
            if (last) begin
                carryout <= cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                overflow <= cout ^ c_msb;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an arithmetic reference model.
module tb_serial_adder;

    localparam int W     = 8;
    localparam int D     = 2;
    localparam int STEPS = W / D;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0, carryin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, carryout, busy, overflow;
    logic [W-1:0] sum;
    int           errors = 0, checks = 0, cyc = 0;

    logic        w_in_valid[2], w_out_ready[2], w_cin[2];
    logic [15:0] w_a[2], w_b[2], w_sum[2];
    logic        w_in_ready[2], w_out_valid[2], w_cout[2], w_busy[2], w_ovf[2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carryin(carryin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carryout(carryout),
`ifdef SERIAL_ADDER_OVERFLOW_EN
        .overflow(overflow),
`endif
        .busy(busy)
    );

    serial_adder #(.WIDTH(16), .DIGIT(16)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid[0]), .in_ready(w_in_ready[0]),
        .a(w_a[0]), .b(w_b[0]), .carryin(w_cin[0]), .out_valid(w_out_valid[0]),
        .out_ready(w_out_ready[0]), .sum(w_sum[0]), .carryout(w_cout[0]),
`ifdef SERIAL_ADDER_OVERFLOW_EN
        .overflow(w_ovf[0]),
`endif
        .busy(w_busy[0])
    );

    serial_adder #(.WIDTH(16), .DIGIT(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid[1]), .in_ready(w_in_ready[1]),
        .a(w_a[1]), .b(w_b[1]), .carryin(w_cin[1]), .out_valid(w_out_valid[1]),
        .out_ready(w_out_ready[1]), .sum(w_sum[1]), .carryout(w_cout[1]),
`ifdef SERIAL_ADDER_OVERFLOW_EN
        .overflow(w_ovf[1]),
`endif
        .busy(w_busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t;
        t = int'(x) + int'(y) + int'(c);
        return (W+1)'(t);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx, sy, t;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        t  = sx + sy + int'(c);
        return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
    endfunction

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input int hold, input string tag);
        logic [W:0] e;
        int n;
        e = ref_add(x, y, c);
        n = 0;
        in_valid = 1'b1; a = x; b = y; carryin = c;
        out_ready = (hold == 0);
        chk({tag, " in_ready idle"}, in_ready, 1);
        tick();
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); carryin = 1'($urandom);
        while (!out_valid && n < 40) begin
            chk({tag, " busy/in_ready run"}, {busy, in_ready}, 2'b10);
            tick();
            n++;
        end
        chk({tag, " latency"}, n, STEPS);
        chk({tag, " sum"}, sum, e[W-1:0]);
        chk({tag, " carryout"}, carryout, e[W]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk({tag, " overflow"}, overflow, ref_ovf(x, y, c));
`endif
        chk({tag, " in_ready done"}, in_ready, 0);
        repeat (hold) begin
            tick();
            chk({tag, " held valid"}, out_valid, 1);
            chk({tag, " held sum"}, sum, e[W-1:0]);
            chk({tag, " held in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, " out_valid dropped"}, out_valid, 0);
        chk({tag, " in_ready back"}, {in_ready, busy}, 2'b10);
    endtask

    task automatic wide_op(input int i, input int exp_steps, input string tag);
        int n;
        n = 0;
        w_in_valid[i] = 1'b1; w_a[i] = 16'hFFFF; w_b[i] = 16'h0001; w_cin[i] = 1'b0;
        w_out_ready[i] = 1'b1;
        tick();
        w_in_valid[i] = 1'b0; w_a[i] = 16'h1234; w_b[i] = 16'h4321;
        while (!w_out_valid[i] && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, exp_steps);
        chk({tag, " sum"}, w_sum[i], 16'h0000);
        chk({tag, " carryout"}, w_cout[i], 1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk({tag, " overflow"}, w_ovf[i], 0);
`endif
        tick();
        chk({tag, " out_valid dropped"}, w_out_valid[i], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] xs[3], ys[3];
        logic         cs[3];
        logic [W:0]   e;
        int           acc[3];
        int           n;
        for (int i = 0; i < 2; i++) begin
            w_in_valid[i] = 1'b0; w_out_ready[i] = 1'b0; w_cin[i] = 1'b0;
            w_a[i] = '0; w_b[i] = '0;
        end
        #12;
        chk("reset handshake", {in_ready, out_valid, busy}, 3'b100);
        chk("reset sum", sum, 0);
        chk("reset carryout", carryout, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("reset overflow", overflow, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h3C, 8'h45, 1'b0, 0, "op 3c+45");
        do_op(8'hFF, 8'h00, 1'b1, 0, "op ff+00+1");
        do_op(8'h10, 8'h20, 1'b0, 5, "backpressure");

        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; carryin = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midreset handshake", {in_ready, out_valid, busy}, 3'b100);
        chk("midreset sum", sum, 0);
        chk("midreset carryout", carryout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h01, 8'h01, 1'b0, 0, "after reset");

        for (int j = 0; j < 3; j++) begin
            xs[j] = W'($urandom); ys[j] = W'($urandom); cs[j] = 1'($urandom);
        end
        out_ready = 1'b1; in_valid = 1'b1; a = xs[0]; b = ys[0]; carryin = cs[0];
        for (int j = 0; j < 3; j++) begin
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            tick();
            acc[j] = cyc;
            e = ref_add(xs[j], ys[j], cs[j]);
            if (j < 2) begin
                a = xs[j+1]; b = ys[j+1]; carryin = cs[j+1];
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 40) begin
                tick();
                n++;
            end
            chk("b2b latency", n, STEPS);
            chk("b2b sum", sum, e[W-1:0]);
            chk("b2b carryout", carryout, e[W]);
            chk("b2b no accept in done", in_ready, 0);
            if (j > 0) chk("b2b period", acc[j] - acc[j-1], STEPS + 2);
        end
        tick();

        for (int k = 0; k < 20; k++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2), "random");

        wide_op(0, 1, "w16 d16");
        wide_op(1, 16, "w16 d1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
